// File: rtl/alu_ctrl_unit.sv
// alu_ctrl_unit: two-stage control front-end for the ALU.
//   Stage 1 (S1) registers the decoded ALU operation (o_ctrl) and the branch
//   condition for an accepted instruction. Stage 2 (S2) samples the ALU flags
//   when S1 advances, resolves the branch and presents the result downstream.
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_valid / o_ready     upstream decode handshake (o_ready combinational)
//   i_opcode, i_funct3,
//   i_funct7b5            instruction fields to decode
//   o_ctrl                registered 4-bit ALU operation code (S1)
//   i_zero, i_negU        ALU flags, sampled only when S1 moves into S2
//   o_valid / i_res_ready downstream result handshake
//   o_is_branch, o_taken,
//   o_illegal             registered S2 result fields
module alu_ctrl_unit (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  output logic [3:0] o_ctrl,
  input  logic       i_zero,
  input  logic       i_negU,
  output logic       o_valid,
  input  logic       i_res_ready,
  output logic       o_is_branch,
  output logic       o_taken,
  output logic       o_illegal
);

  localparam int unsigned CTRL_W = 4;
  localparam int unsigned OPC_W  = 7;

  // ALU operation encodings
  localparam logic [CTRL_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_OR   = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_AND  = 4'b0011;
  localparam logic [CTRL_W-1:0] ALU_XOR  = 4'b0100;
  localparam logic [CTRL_W-1:0] ALU_SRA  = 4'b0101;
  localparam logic [CTRL_W-1:0] ALU_SRL  = 4'b0110;
  localparam logic [CTRL_W-1:0] ALU_SLL  = 4'b0111;
  localparam logic [CTRL_W-1:0] ALU_SLT  = 4'b1101;
  localparam logic [CTRL_W-1:0] ALU_SLTU = 4'b1110;

  // Instruction opcodes
  localparam logic [OPC_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_I      = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;

  // Branch condition: bit 1 picks the flag (0 = zero, 1 = negU), bit 0 inverts it.
  typedef enum logic [1:0] {
    COND_Z  = 2'b00,
    COND_NZ = 2'b01,
    COND_N  = 2'b10,
    COND_NN = 2'b11
  } cond_e;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic              is_branch;
    cond_e             cond;
    logic              illegal;
  } s1_info_t;

  s1_info_t dec_c;
  s1_info_t s1_q;
  logic     s1_valid;
  logic     s2_valid;
  logic     s2_adv_c;
  logic     s1_adv_c;
  logic     accept_c;
  logic     flag_c;
  logic     taken_c;

  // Instruction decode into ALU op, branch condition and legality
  always_comb begin
    dec_c.ctrl      = ALU_ADD;
    dec_c.is_branch = 1'b0;
    dec_c.cond      = COND_Z;
    dec_c.illegal   = 1'b0;
    case (i_opcode)
      OP_R, OP_I: begin
        case (i_funct3)
          3'b000: dec_c.ctrl = (i_opcode == OP_R && i_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001: begin
            dec_c.ctrl = ALU_SLL;
            // slli with bit 30 set has no defined meaning
            if (i_opcode == OP_I && i_funct7b5) begin
              dec_c.illegal = 1'b1;
            end
          end
          3'b010: dec_c.ctrl = ALU_SLT;
          3'b011: dec_c.ctrl = ALU_SLTU;
          3'b100: dec_c.ctrl = ALU_XOR;
          3'b101: dec_c.ctrl = i_funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110: dec_c.ctrl = ALU_OR;
          3'b111: dec_c.ctrl = ALU_AND;
        endcase
      end
      OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: begin
        dec_c.ctrl = ALU_ADD;
      end
      OP_BRANCH: begin
        dec_c.is_branch = 1'b1;
        case (i_funct3)
          3'b000: begin dec_c.ctrl = ALU_SUB; dec_c.cond = COND_Z;  end
          3'b001: begin dec_c.ctrl = ALU_SUB; dec_c.cond = COND_NZ; end
          // signed compares run Slt: result 1 means less-than, so zero means not-less
          3'b100: begin dec_c.ctrl = ALU_SLT; dec_c.cond = COND_NZ; end
          3'b101: begin dec_c.ctrl = ALU_SLT; dec_c.cond = COND_Z;  end
          3'b110: begin dec_c.ctrl = ALU_SUB; dec_c.cond = COND_N;  end
          3'b111: begin dec_c.ctrl = ALU_SUB; dec_c.cond = COND_NN; end
          default: dec_c.illegal = 1'b1;
        endcase
      end
      default: dec_c.illegal = 1'b1;
    endcase
    // Illegal instructions still occupy a slot but drive a neutral ALU op
    if (dec_c.illegal) begin
      dec_c.ctrl      = ALU_ADD;
      dec_c.is_branch = 1'b0;
      dec_c.cond      = COND_Z;
    end
  end

  // Pipeline handshake
  always_comb begin
    s2_adv_c = !s2_valid || i_res_ready;
    s1_adv_c = s1_valid && s2_adv_c;
    o_ready  = !s1_valid || s2_adv_c;
    accept_c = i_valid && o_ready;
  end

  // Branch resolution from the flags of the instruction leaving S1
  always_comb begin
    flag_c  = s1_q.cond[1] ? i_negU : i_zero;
    taken_c = s1_q.is_branch && (flag_c ^ s1_q.cond[0]);
  end

  // Stage 1: decoded instruction, drives the ALU
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (accept_c) begin
      s1_valid <= 1'b1;
      s1_q     <= dec_c;
    end else if (s1_adv_c) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: resolved result presented downstream
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s2_valid    <= 1'b0;
      o_is_branch <= 1'b0;
      o_taken     <= 1'b0;
      o_illegal   <= 1'b0;
    end else if (s1_adv_c) begin
      s2_valid    <= 1'b1;
      o_is_branch <= s1_q.is_branch;
      o_taken     <= taken_c;
      o_illegal   <= s1_q.illegal;
    end else if (s2_valid && i_res_ready) begin
      s2_valid <= 1'b0;
    end
  end

  assign o_ctrl  = s1_q.ctrl;
  assign o_valid = s2_valid;

endmodule

// File: tb/tb_alu_ctrl_unit.sv
// Self-checking bench for alu_ctrl_unit: a transaction-level model decodes
// instructions from the instruction-set tables and tracks the two slots.
module tb_alu_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_valid;
  logic       o_ready;
  logic [6:0] i_opcode;
  logic [2:0] i_funct3;
  logic       i_funct7b5;
  logic [3:0] o_ctrl;
  logic       i_zero;
  logic       i_negU;
  logic       o_valid;
  logic       i_res_ready;
  logic       o_is_branch;
  logic       o_taken;
  logic       o_illegal;

  int errors = 0;
  int checks = 0;

  alu_ctrl_unit dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_opcode    (i_opcode),
    .i_funct3    (i_funct3),
    .i_funct7b5  (i_funct7b5),
    .o_ctrl      (o_ctrl),
    .i_zero      (i_zero),
    .i_negU      (i_negU),
    .o_valid     (o_valid),
    .i_res_ready (i_res_ready),
    .o_is_branch (o_is_branch),
    .o_taken     (o_taken),
    .o_illegal   (o_illegal)
  );

  always #5 clk = ~clk;

  localparam bit [6:0] OP_R = 7'b0110011;
  localparam bit [6:0] OP_I = 7'b0010011;
  localparam bit [6:0] OP_B = 7'b1100011;

  typedef struct {
    bit [3:0] ctrl;
    bit       br;
    bit       ill;
    bit [2:0] f3;
  } mdec_t;

  // Model state: slot 1 (decoded, driving ALU), slot 2 (result)
  bit       m1v, m2v;
  mdec_t    m1;
  bit [3:0] m_ctrl;
  bit       m2_br, m2_taken, m2_ill;
  bit       exp_ready, obs_ready;
  int       acc_count = 0;

  logic [7:0] obs_out, exp_out;
  assign obs_out = {o_valid, o_is_branch, o_taken, o_illegal, o_ctrl};
  assign exp_out = {m2v, m2_br, m2_taken, m2_ill, m_ctrl};

  function automatic mdec_t ref_decode(bit [6:0] op, bit [2:0] f3, bit f7);
    mdec_t    d;
    bit [3:0] alu_tab [8];
    // funct3 -> ALU op for register/immediate arithmetic
    alu_tab = '{4'b0000, 4'b0111, 4'b1101, 4'b1110, 4'b0100, 4'b0110, 4'b0010, 4'b0011};
    d.ctrl = 4'b0000; d.br = 1'b0; d.ill = 1'b0; d.f3 = f3;
    if (op == OP_R || op == OP_I) begin
      d.ctrl = alu_tab[f3];
      if (f7 && f3 == 3'd5) d.ctrl = 4'b0101;
      if (f7 && f3 == 3'd0 && op == OP_R) d.ctrl = 4'b0001;
      if (op == OP_I && f3 == 3'd1 && f7) d.ill = 1'b1;
    end else if (op inside {7'b0000011, 7'b0100011, 7'b1101111, 7'b1100111,
                            7'b0110111, 7'b0010111}) begin
      d.ctrl = 4'b0000;
    end else if (op == OP_B) begin
      if (f3 == 3'd2 || f3 == 3'd3) d.ill = 1'b1;
      else begin
        d.br   = 1'b1;
        d.ctrl = (f3 == 3'd4 || f3 == 3'd5) ? 4'b1101 : 4'b0001;
      end
    end else begin
      d.ill = 1'b1;
    end
    if (d.ill) d.ctrl = 4'b0000;
    return d;
  endfunction

  function automatic bit ref_taken(mdec_t d, bit z, bit n);
    if (!d.br) return 1'b0;
    case (d.f3)
      3'd0: return z;    // beq
      3'd1: return !z;   // bne
      3'd4: return !z;   // blt
      3'd5: return z;    // bge
      3'd6: return n;    // bltu
      default: return !n; // bgeu
    endcase
  endfunction

  task automatic model_reset();
    m1v = 0; m2v = 0; m_ctrl = 0; m2_br = 0; m2_taken = 0; m2_ill = 0;
  endtask

  // One clock: drive inputs, capture o_ready, advance DUT and model together.
  task automatic step(input bit v, input bit [6:0] op, input bit [2:0] f3, input bit f7,
                      input bit z, input bit n, input bit rr);
    bit acc, s2a, s1a;
    i_valid = v; i_opcode = op; i_funct3 = f3; i_funct7b5 = f7;
    i_zero = z; i_negU = n; i_res_ready = rr;
    #1;
    exp_ready = !m1v || !m2v || rr;
    obs_ready = o_ready;
    s2a = !m2v || rr;
    s1a = m1v && s2a;
    acc = v && exp_ready;
    @(posedge clk);
    if (s1a) begin
      m2v = 1; m2_br = m1.br; m2_ill = m1.ill; m2_taken = ref_taken(m1, z, n);
    end else if (m2v && rr) begin
      m2v = 0;
    end
    if (acc) begin
      m1 = ref_decode(op, f3, f7); m1v = 1; m_ctrl = m1.ctrl; acc_count++;
    end else if (s1a) begin
      m1v = 0;
    end
    #1;
  endtask

  task automatic rand_instr(output bit [6:0] op, output bit [2:0] f3, output bit f7);
    bit [6:0] ops [10];
    ops = '{OP_R, OP_I, OP_B, 7'b0000011, 7'b0100011, 7'b1101111,
            7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};
    op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
    f3 = 3'($urandom);
    f7 = 1'($urandom);
  endtask

  task automatic test_reset();
    rst = 1; i_valid = 0; i_opcode = 0; i_funct3 = 0; i_funct7b5 = 0;
    i_zero = 0; i_negU = 0; i_res_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    #1;
    checks++;
    if ({o_valid, o_ctrl, o_is_branch, o_taken, o_illegal} !== 8'h00) begin
      errors++; $display("FAIL reset_state got=%b exp=00000000",
                         {o_valid, o_ctrl, o_is_branch, o_taken, o_illegal});
    end
    checks++;
    if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
    // Fill both slots: illegal in S2, sub in S1
    step(1, 7'b1111111, 3'd0, 0, 0, 0, 0);
    step(1, OP_R, 3'd0, 1, 0, 0, 0);
    checks++;
    if (obs_out !== exp_out) begin errors++; $display("FAIL reset_fill got=%b exp=%b", obs_out, exp_out); end
    rst = 1;
    #1;
    checks++;
    if ({o_valid, o_ctrl, o_is_branch, o_taken, o_illegal} !== 8'h00) begin
      errors++; $display("FAIL reset_async got=%b exp=00000000",
                         {o_valid, o_ctrl, o_is_branch, o_taken, o_illegal});
    end
    model_reset();
    @(posedge clk);
    #1 rst = 0; i_valid = 0; i_res_ready = 0;
    #1;
    checks++;
    if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b exp=1", o_ready); end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 1, 1, 1);
      checks++;
      if (obs_out !== exp_out) begin
        errors++; $display("FAIL reset_stale[%0d] got=%b exp=%b", i, obs_out, exp_out);
      end
    end
  endtask

  task automatic test_rtype();
    bit [2:0] f3s [4];
    bit       f7s [4];
    bit [3:0] exps [4];
    bit [6:0] op; bit [2:0] f3; bit f7;
    f3s = '{3'd0, 3'd5, 3'd3, 3'd6};
    f7s = '{1'b1, 1'b1, 1'b0, 1'b0};
    exps = '{4'b0001, 4'b0101, 4'b1110, 4'b0010};
    for (int i = 0; i < 4; i++) begin
      step(1, OP_R, f3s[i], f7s[i], 0, 0, 1);
      checks++;
      if (o_ctrl !== exps[i]) begin
        errors++; $display("FAIL rtype_ctrl[%0d] got=%b exp=%b", i, o_ctrl, exps[i]);
      end
    end
    for (int i = 0; i < 24; i++) begin
      op = ($urandom_range(0, 1) == 0) ? OP_R : OP_I;
      f3 = 3'($urandom); f7 = 1'($urandom);
      step(1, op, f3, f7, 1'($urandom), 1'($urandom), 1);
      checks++;
      if (obs_out !== exp_out) begin
        errors++; $display("FAIL rtype_rand[%0d] got=%b exp=%b", i, obs_out, exp_out);
      end
    end
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_branch();
    bit [2:0] f3s [3];
    bit       z1 [3], z2 [3], n1 [3], n2 [3];
    bit [6:0] op; bit [2:0] f3; bit f7;
    // beq z=1 -> taken; bge z=0 -> not taken; bltu negU=1 -> taken
    f3s = '{3'd0, 3'd5, 3'd6};
    z1 = '{1'b0, 1'b1, 1'b0}; z2 = '{1'b1, 1'b0, 1'b0};
    n1 = '{1'b0, 1'b0, 1'b0}; n2 = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      step(1, OP_B, f3s[i], 0, z1[i], n1[i], 1);
      step(0, 0, 0, 0, z2[i], n2[i], 1);
      checks++;
      if ({o_valid, o_is_branch, o_taken} !== {2'b11, (i != 1)}) begin
        errors++; $display("FAIL branch_dir[%0d] got=%b exp=%b", i,
                           {o_valid, o_is_branch, o_taken}, {2'b11, (i != 1)});
      end
    end
    for (int i = 0; i < 30; i++) begin
      op = ($urandom_range(0, 3) == 0) ? OP_R : OP_B;
      f3 = 3'($urandom); f7 = 1'($urandom);
      step(1, op, f3, f7, 1'($urandom), 1'($urandom), 1);
      checks++;
      if (obs_out !== exp_out) begin
        errors++; $display("FAIL branch_rand[%0d] got=%b exp=%b", i, obs_out, exp_out);
      end
    end
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_backpressure();
    bit [6:0] ops [4];
    int       base;
    // Four add-class instructions, distinguishable by their flags/class
    ops = '{OP_R, 7'b0000011, 7'b0100011, 7'b0110111};
    base = acc_count;
    step(1, ops[0], 0, 0, 0, 0, 0);
    step(1, ops[1], 0, 0, 1, 1, 0);
    step(1, ops[2], 0, 0, 0, 0, 0);
    checks++;
    if (obs_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full got=%b exp=0", obs_ready); end
    for (int i = 0; i < 3; i++) begin
      step(1, ops[2], 0, 0, 1'($urandom), 1'($urandom), 0);
      checks++;
      if (obs_out !== exp_out) begin
        errors++; $display("FAIL bp_hold[%0d] got=%b exp=%b", i, obs_out, exp_out);
      end
    end
    step(1, ops[2], 0, 0, 0, 0, 1);
    step(1, ops[3], 0, 0, 0, 0, 0);
    checks++;
    if (acc_count - base !== 3) begin
      errors++; $display("FAIL bp_accepts got=%0d exp=3", acc_count - base);
    end
    checks++;
    if (obs_out !== exp_out) begin errors++; $display("FAIL bp_after got=%b exp=%b", obs_out, exp_out); end
    step(1, ops[3], 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0, 1);
      checks++;
      if (obs_out !== exp_out) begin
        errors++; $display("FAIL bp_drain[%0d] got=%b exp=%b", i, obs_out, exp_out);
      end
    end
  endtask

  task automatic test_illegal();
    bit [6:0] ops [3];
    bit [2:0] f3s [3];
    bit       f7s [3];
    ops = '{7'b1111111, OP_B, OP_I};
    f3s = '{3'd0, 3'd2, 3'd1};
    f7s = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      step(1, ops[i], f3s[i], f7s[i], 1, 1, 1);
      step(0, 0, 0, 0, 1, 1, 1);
      checks++;
      if ({o_valid, o_illegal, o_ctrl, o_taken, o_is_branch} !== 8'b11_0000_00) begin
        errors++; $display("FAIL illegal[%0d] got=%b exp=11000000", i,
                           {o_valid, o_illegal, o_ctrl, o_taken, o_is_branch});
      end
    end
    step(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_throughput();
    bit [6:0] op; bit [2:0] f3; bit f7;
    int vcount = 0;
    for (int i = 0; i < 9; i++) begin
      rand_instr(op, f3, f7);
      step(i < 8, op, f3, f7, 1'($urandom), 1'($urandom), 1);
      if (i >= 1 && o_valid === 1'b1) vcount++;
      checks++;
      if (obs_out !== exp_out) begin
        errors++; $display("FAIL tput[%0d] got=%b exp=%b", i, obs_out, exp_out);
      end
    end
    checks++;
    if (vcount !== 8) begin errors++; $display("FAIL tput_count got=%0d exp=8", vcount); end
  endtask

  task automatic test_random();
    bit [6:0] op; bit [2:0] f3; bit f7;
    for (int i = 0; i < 400; i++) begin
      rand_instr(op, f3, f7);
      step(1'($urandom_range(0, 3) != 0), op, f3, f7, 1'($urandom), 1'($urandom),
           1'($urandom_range(0, 2) != 0));
      checks++;
      if (obs_ready !== exp_ready) begin
        errors++; $display("FAIL rand_ready[%0d] got=%b exp=%b", i, obs_ready, exp_ready);
      end
      checks++;
      if (obs_out !== exp_out) begin
        errors++; $display("FAIL rand_out[%0d] got=%b exp=%b", i, obs_out, exp_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_branch();
    test_backpressure();
    test_illegal();
    test_throughput();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_unit.md
Name: alu_ctrl_unit

Overview:
- Pipelined control front-end that drives the ALU and consumes its result flags.
- Accepts decoded instruction fields over a valid/ready handshake and registers the 4-bit ALU operation code into the ALU.
- On the next stage it captures the ALU's zero/unsigned-less-than flags to resolve branches, then presents the outcome downstream with backpressure.
- Sits between the instruction-decode stage and branch/writeback logic.

Parameters:
- None. The ALU code encodings are fixed: Add 0000, Sub 0001, Or 0010, And 0011, Xor 0100, Sra 0101, Srl 0110, Sll 0111, Slt 1101, Sltu 1110.

Ports:
- i_clk  input  1  clock; all state updates on rising edge
- i_rst  input  1  reset; asynchronous, active-high; all state cleared
- i_valid  input  1  upstream instruction valid
- o_ready  output  1  unit can accept; combinational
- i_opcode  input  7  instruction opcode
- i_funct3  input  3  instruction funct3
- i_funct7b5  input  1  instruction bit 30
- o_ctrl  output  4  ALU operation code, registered (stage 1)
- i_zero  input  1  ALU result == 0
- i_negU  input  1  ALU unsigned operand-1 < operand-2
- o_valid  output  1  stage-2 result valid
- i_res_ready  input  1  downstream accepts result
- o_is_branch  output  1  stage-2 instruction is a conditional branch
- o_taken  output  1  branch resolved taken; 0 for non-branches
- o_illegal  output  1  unsupported opcode/funct combination

Behaviour:
- Two stages: S1 holds decoded ctrl/branch info and drives o_ctrl; S2 holds the resolved result.
- Reset (async, any time including mid-transfer): S1 and S2 valid cleared, o_ctrl=0000, o_is_branch/o_taken/o_illegal=0, o_valid=0. In-flight instructions are discarded. o_ready=1 once reset is released.
- Handshakes:
  - s2_adv = !s2_valid | i_res_ready.
  - s1_adv = s1_valid & s2_adv.
  - o_ready = !s1_valid | s2_adv.
  - Accept on edge where i_valid & o_ready.
- Edge behaviour:
  - On accept, S1 loads the decode and s1_valid=1.
  - Else if s1_adv, s1_valid=0 and o_ctrl holds its last value.
  - On s1_adv, S2 loads S1 info and samples i_zero/i_negU to compute o_taken; s2_valid=1.
  - Else if o_valid & i_res_ready, s2_valid=0.
  - S2 outputs hold while o_valid & !i_res_ready.
- Latency and throughput: accepted at edge N, o_ctrl valid from N to the ALU; flags sampled at edge N+1 if S2 is free; o_valid from N+1. Throughput is one per cycle. Simultaneous accept, S1→S2 move, and S2 drain are all legal in one edge.
- The datapath keeps ALU operands aligned with o_ctrl while s1_valid. Flags are sampled only on s1_adv; flag values on any other cycle are ignored.
- Decode, opcode 0110011 (R-type):
  - funct3 000: Sub if funct7b5 else Add
  - 001 Sll; 010 Slt; 011 Sltu; 100 Xor
  - 101: Sra if funct7b5 else Srl
  - 110 Or; 111 And
- Decode, opcode 0010011 (I-type): same as R-type except:
  - funct3 000 is always Add.
  - 001 with funct7b5=1 is illegal.
- Decode, address/immediate opcodes: 0000011, 0100011, 1101111, 1100111, 0110111, 0010111 → Add, not a branch.
- Decode, opcode 1100011 (branch), is_branch=1:
  - 000 beq: Sub, taken=i_zero
  - 001 bne: Sub, taken=!i_zero
  - 100 blt: Slt, taken=!i_zero
  - 101 bge: Slt, taken=i_zero
  - 110 bltu: Sub, taken=i_negU
  - 111 bgeu: Sub, taken=!i_negU
  - 010/011: illegal
- Illegal instructions: ctrl=0000, is_branch=0, taken=0, o_illegal=1. The instruction still flows through both stages and occupies a slot.
- o_taken is forced to 0 when is_branch=0.

Test Plan:
- Reset: assert i_rst mid-stream with both stages full → o_valid=0 and o_ctrl=0000 immediately (async); after release o_ready=1, and no stale result appears.
- R-type sweep: opcode 0110011, funct3 000/funct7b5=1 → o_ctrl=0001 one edge after accept. Also funct3 101/funct7b5=1 → 0101; funct3 011 → 1110; funct3 110 → 0010.
- Branch resolve:
  - beq with i_zero=1 at sample edge → o_valid=1, o_is_branch=1, o_taken=1.
  - bge with i_zero=0 → o_taken=0.
  - bltu with i_negU=1 → o_taken=1.
- Backpressure: stream 4 back-to-back adds while holding i_res_ready=0 → after 2 accepts o_ready=0, and S2 outputs are stable. Releasing i_res_ready for 1 cycle accepts exactly one more instruction, in order, with none lost or duplicated.
- Illegal: opcode 1111111, and branch funct3 010, and I-type funct3 001 with funct7b5=1 → o_illegal=1, o_ctrl=0000, o_taken=0.
- Throughput: 8 consecutive valid instructions with i_res_ready=1 → 8 results on consecutive cycles starting one cycle after the first accept, with flags sampled per instruction.
